// File: rtl/cpu_control_unit_if.sv
// Instruction ROM and register-file port bundle for cpu_control_unit.
// The control unit is the master: it drives addresses, write data and write enable.
interface cpu_control_unit_if #(
    parameter int PC_WIDTH = 6
) ();
    // Bus timing. The ROM and register file return registered data: instr_data
    // belongs to the instr_addr presented one cycle earlier, and reg1_data/reg2_data
    // belong to the read_reg1/read_reg2 presented one cycle earlier. A write happens
    // at the end of any cycle in which signal_regwrite is high. There is no
    // back-pressure: the slave side must always accept.
    logic [PC_WIDTH-1:0] instr_addr;
    logic [7:0]          instr_data;
    logic [1:0]          read_reg1;
    logic [1:0]          read_reg2;
    logic [7:0]          reg1_data;
    logic [7:0]          reg2_data;
    logic [1:0]          write_reg;
    logic [7:0]          write_data;
    logic                signal_regwrite;

    modport master (
        output instr_addr,
        output read_reg1,
        output read_reg2,
        output write_reg,
        output write_data,
        output signal_regwrite,
        input  instr_data,
        input  reg1_data,
        input  reg2_data
    );

    modport slave (
        input  instr_addr,
        input  read_reg1,
        input  read_reg2,
        input  write_reg,
        input  write_data,
        input  signal_regwrite,
        output instr_data,
        output reg1_data,
        output reg2_data
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for the 8-bit four-register datapath: fetch, decode,
// execute (ADD/SUB/LI/JMP) and write-back through fixed FSM states.
module cpu_control_unit #(
    parameter int PC_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    cpu_control_unit_if.master    bus,
    output logic                  busy,
    output logic                  halted,
    output logic                  flag_zero,
    output logic                  flag_carry,
    output logic [2:0]            state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LI  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [7:0]          ir;
    logic [7:0]          result;

    logic [1:0]          opcode;
    logic [1:0]          rs;
    logic [1:0]          rt;
    logic [1:0]          rd;
    logic [PC_WIDTH-1:0] jmp_target;

    logic [8:0]          add_sum;
    logic [7:0]          sub_diff;
    logic [7:0]          alu_result;
    logic                alu_carry;

    assign opcode     = ir[7:6];
    assign rs         = ir[5:4];
    assign rt         = ir[3:2];
    assign rd         = ir[1:0];
    assign jmp_target = PC_WIDTH'(ir[5:0]);
    assign state_dbg  = state;

    // Operands come straight from the registered read ports; only valid in EXECUTE.
    always_comb begin
        add_sum    = {1'b0, bus.reg1_data} + {1'b0, bus.reg2_data};
        sub_diff   = bus.reg1_data - bus.reg2_data;
        alu_result = '0;
        alu_carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_result = add_sum[7:0];
                alu_carry  = add_sum[8];
            end
            OP_SUB: begin
                alu_result = sub_diff;
                alu_carry  = (bus.reg1_data >= bus.reg2_data);
            end
            OP_LI: begin
                alu_result = {{4{ir[5]}}, ir[5:2]};
            end
            default: begin
                alu_result = '0;
                alu_carry  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next          = state;
        busy                = 1'b1;
        halted              = 1'b0;
        bus.instr_addr      = pc;
        bus.read_reg1       = '0;
        bus.read_reg2       = '0;
        bus.write_reg       = '0;
        bus.write_data      = '0;
        bus.signal_regwrite = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                bus.read_reg1 = rs;
                bus.read_reg2 = rt;
                state_next    = S_EXECUTE;
            end
            S_EXECUTE: begin
                bus.read_reg1 = rs;
                bus.read_reg2 = rt;
                if (opcode != OP_JMP) begin
                    state_next = S_WRITEBACK;
                end else if (jmp_target == pc) begin
                    // A jump to itself can never make progress, so treat it as halt.
                    state_next = S_HALT;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_WRITEBACK: begin
                bus.read_reg1 = rs;
                bus.read_reg2 = rt;
                // Reset in this cycle must not corrupt the destination register.
                if (!reset) begin
                    bus.write_reg       = rd;
                    bus.write_data      = result;
                    bus.signal_regwrite = 1'b1;
                end
                state_next = S_FETCH;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= '0;
            ir         <= '0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            case (state)
                S_FETCH_WAIT: begin
                    ir <= bus.instr_data;
                end
                S_EXECUTE: begin
                    if (opcode == OP_JMP) begin
                        if (jmp_target != pc) begin
                            pc <= jmp_target;
                        end
                    end else begin
                        result <= alu_result;
                        // LI loads a constant and leaves the flags alone.
                        if (opcode != OP_LI) begin
                            flag_zero  <= (alu_result == 8'h00);
                            flag_carry <= alu_carry;
                        end
                    end
                end
                S_WRITEBACK: begin
                    pc <= pc + PC_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: ROM and register-file models, table vectors,
// directed multi-cycle sequences and random programs against an ISA-level model.
module tb_cpu_control_unit;
    localparam int PC_WIDTH = 6;
    localparam int EXP_W    = 25;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       halted;
    logic       flag_zero;
    logic       flag_carry;
    logic [2:0] state_dbg;

    cpu_control_unit_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    cpu_control_unit #(.PC_WIDTH(PC_WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .halted     (halted),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- memory models ----------------
    logic [7:0] rom [64];
    logic [7:0] rf  [4];
    logic       pl_en = 1'b0;
    logic [1:0] pl_addr = 2'd0;
    logic [7:0] pl_val = 8'd0;

    always @(posedge clock) begin
        bus.instr_data <= rom[bus.instr_addr];
    end

    always @(posedge clock) begin
        if (pl_en) begin
            rf[pl_addr] <= pl_val;
        end else if (bus.signal_regwrite) begin
            rf[bus.write_reg] <= bus.write_data;
        end
        bus.reg1_data <= rf[bus.read_reg1];
        bus.reg2_data <= rf[bus.read_reg2];
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q [$];
    logic [7:0]       m_regs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack(input logic [5:0] pc, input logic b, input logic h,
                                              input logic we, input logic [1:0] wr, input logic [7:0] wd,
                                              input logic [1:0] r1, input logic [1:0] r2,
                                              input logic z, input logic c);
        return {pc, b, h, we, wr, wd, r1, r2, z, c};
    endfunction

    function automatic logic [EXP_W-1:0] actual();
        return pack(bus.instr_addr, busy, halted, bus.signal_regwrite, bus.write_reg, bus.write_data,
                    bus.read_reg1, bus.read_reg2, flag_zero, flag_carry);
    endfunction

    // ISA-level model: executes the program instruction by instruction and emits
    // what the outputs must look like in every cycle of each instruction.
    task automatic build_expect(input int max_instr);
        logic [5:0] pc;
        logic [7:0] r [4];
        logic       z, c, nz, nc;
        logic [7:0] ins, a, b, res;
        logic [8:0] s;
        pc = 6'd0;
        z  = 1'b0;
        c  = 1'b0;
        r  = m_regs;
        for (int n = 0; n < max_instr; n++) begin
            ins = rom[pc];
            if (ins[7:6] == 2'b11) begin
                for (int k = 0; k < 4; k++)
                    exp_q.push_back(pack(pc, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0,
                                         (k >= 2) ? ins[5:4] : 2'd0, (k >= 2) ? ins[3:2] : 2'd0, z, c));
                if (ins[5:0] == pc) begin
                    for (int k = 0; k < 4; k++)
                        exp_q.push_back(pack(pc, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 2'd0, 2'd0, z, c));
                    return;
                end
                pc = ins[5:0];
            end else begin
                a  = r[ins[5:4]];
                b  = r[ins[3:2]];
                nz = z;
                nc = c;
                res = 8'd0;
                if (ins[7:6] == 2'b00) begin
                    s   = 9'(a) + 9'(b);
                    res = s[7:0];
                    nc  = (s >= 9'd256);
                    nz  = (res == 8'd0);
                end else if (ins[7:6] == 2'b01) begin
                    res = a - b;
                    nc  = (a >= b);
                    nz  = (a == b);
                end else begin
                    res = 8'(int'(ins[5:2]) - (ins[5] ? 16 : 0));
                end
                for (int k = 0; k < 4; k++)
                    exp_q.push_back(pack(pc, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0,
                                         (k >= 2) ? ins[5:4] : 2'd0, (k >= 2) ? ins[3:2] : 2'd0, z, c));
                exp_q.push_back(pack(pc, 1'b1, 1'b0, 1'b1, ins[1:0], res, ins[5:4], ins[3:2], nz, nc));
                r[ins[1:0]] = res;
                z  = nz;
                c  = nc;
                pc = pc + 6'd1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] v);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_val  = v;
        m_regs[a] = v;
        @(posedge clock);
        #1 pl_en = 1'b0;
    endtask

    // Leaves the bench just after the edge that enters cycle 1 (FETCH).
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_halt(input int lim);
        int n = 0;
        while (!halted && n < lim) begin
            @(negedge clock);
            n++;
        end
        check("halt_timeout", 32'(halted), 32'd1);
    endtask

    function automatic logic [7:0] gen_instr(input int a);
        int         k;
        logic [7:0] v;
        k = $urandom_range(0, 9);
        v = 8'($urandom_range(0, 255));
        if (k <= 3) v[7:6] = 2'b00;
        else if (k <= 5) v[7:6] = 2'b01;
        else if (k <= 7) v[7:6] = 2'b10;
        else begin
            v[7:6] = 2'b11;
            if ($urandom_range(0, 1) == 1) v[5:0] = 6'(a);
        end
        return v;
    endfunction

    // ---------------- table vectors ----------------
    typedef struct {
        logic [7:0] instr;
        logic [7:0] va;
        logic [7:0] vb;
        logic [1:0] exp_rd;
        logic [7:0] exp_data;
        logic       exp_z;
        logic       exp_c;
    } vec_t;

    vec_t vecs [9];
    logic [19:0] wr_log [$];
    logic [19:0] wr_exp [3];

    initial begin
        vecs[0] = '{8'h58, 8'h03, 8'h05, 2'd0, 8'hFE, 1'b0, 1'b0};
        vecs[1] = '{8'h54, 8'h03, 8'h03, 2'd0, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'h1B, 8'h05, 8'hFD, 2'd3, 8'h02, 1'b0, 1'b1};
        vecs[3] = '{8'h06, 8'h80, 8'h80, 2'd2, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h2D, 8'h12, 8'h34, 2'd1, 8'h46, 1'b0, 1'b0};
        vecs[5] = '{8'h73, 8'hFF, 8'h01, 2'd3, 8'hFE, 1'b0, 1'b1};
        vecs[6] = '{8'h9C, 8'h00, 8'h00, 2'd0, 8'h07, 1'b0, 1'b0};
        vecs[7] = '{8'hA3, 8'h00, 8'h00, 2'd3, 8'hF8, 1'b0, 1'b0};
        vecs[8] = '{8'h4E, 8'h00, 8'h01, 2'd2, 8'hFF, 1'b0, 1'b0};
        wr_exp[0] = {8'd5,  2'd1, 8'h05, 1'b0, 1'b0};
        wr_exp[1] = {8'd10, 2'd2, 8'hFD, 1'b0, 1'b0};
        wr_exp[2] = {8'd15, 2'd3, 8'h02, 1'b0, 1'b1};
        for (int a = 0; a < 64; a++) rom[a] = 8'h00;
        for (int r = 0; r < 4; r++) rf[r] = 8'h00;

        // Reset state and idle behaviour
        do_reset();
        for (int r = 0; r < 4; r++) preload(2'(r), 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle_outputs", 32'(actual()), 32'd0);
        end
        check("idle_state", 32'(state_dbg), 32'd0);

        // Worked program: LI, LI, ADD, JMP-to-self
        rom[0] = 8'h95; rom[1] = 8'hB6; rom[2] = 8'h1B; rom[3] = 8'hC3;
        pulse_start();
        wr_log.delete();
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                check("start_busy", 32'(busy), 32'd1);
                check("start_addr", 32'(bus.instr_addr), 32'd0);
            end
            if (bus.signal_regwrite)
                wr_log.push_back({8'(cyc), bus.write_reg, bus.write_data, flag_zero, flag_carry});
        end
        check("prog_write_count", 32'(wr_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < wr_log.size()) check("prog_write", 32'(wr_log[i]), 32'(wr_exp[i]));
        check("prog_halted", 32'({halted, busy}), 32'b10);
        check("prog_r3", 32'(rf[3]), 32'h02);

        // start while halted is ignored
        @(posedge clock);
        #1 pulse_start();
        repeat (2) @(negedge clock);
        check("halt_start_ignored", 32'({halted, busy, bus.instr_addr}), {24'd0, 2'b10, 6'd3});

        // Single-instruction vectors
        for (int i = 0; i < 9; i++) begin
            do_reset();
            preload(vecs[i].instr[5:4], vecs[i].va);
            preload(vecs[i].instr[3:2], vecs[i].vb);
            rom[0] = vecs[i].instr;
            rom[1] = 8'hC1;
            pulse_start();
            repeat (4) @(posedge clock);
            @(negedge clock);
            check("vec_write", 32'({bus.signal_regwrite, bus.write_reg, bus.write_data}),
                  32'({1'b1, vecs[i].exp_rd, vecs[i].exp_data}));
            check("vec_flags", 32'({flag_zero, flag_carry}), 32'({vecs[i].exp_z, vecs[i].exp_c}));
            wait_halt(20);
            check("vec_rf", 32'(rf[vecs[i].exp_rd]), 32'(vecs[i].exp_data));
        end

        // Reset during WRITEBACK suppresses the write
        do_reset();
        preload(2'd1, 8'hAA);
        rom[0] = 8'h95;
        rom[1] = 8'hC1;
        pulse_start();
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_wb_regwrite", 32'(bus.signal_regwrite), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_wb_idle", 32'({busy, halted, bus.instr_addr}), 32'd0);
        check("rst_wb_rf_kept", 32'(rf[1]), 32'hAA);
        pulse_start();
        @(negedge clock);
        check("rst_wb_restart", 32'({busy, bus.instr_addr}), {25'd0, 1'b1, 6'd0});

        // PC wrap from 63 to 0
        do_reset();
        rom[0]  = 8'hFF;
        rom[63] = 8'h84;
        pulse_start();
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clock);
            if (cyc == 5) check("wrap_fetch63", 32'(bus.instr_addr), 32'd63);
            if (cyc == 9) check("wrap_write", 32'({bus.signal_regwrite, bus.write_reg, bus.write_data}),
                                {21'd0, 1'b1, 2'd0, 8'h01});
            if (cyc == 10) check("wrap_fetch0", 32'({busy, bus.instr_addr}), {25'd0, 1'b1, 6'd0});
        end

        // Simultaneous start and reset: reset wins
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("start_reset_busy", 32'(busy), 32'd0);

        // Random programs with stray start pulses, against the ISA model
        for (int p = 0; p < 15; p++) begin
            do_reset();
            for (int a = 0; a < 64; a++) rom[a] = gen_instr(a);
            for (int r = 0; r < 4; r++) preload(2'(r), 8'($urandom_range(0, 255)));
            exp_q.delete();
            build_expect(30);
            pulse_start();
            while (exp_q.size() > 0) begin
                @(negedge clock);
                check("trace", 32'(actual()), 32'(exp_q.pop_front()));
                start = ($urandom_range(0, 5) == 0);
            end
            start = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
